// File: rtl/tpu_pkg.sv
// Shared types, address-region codes, CSR bit positions and row-geometry helpers for the tpuv2 block.
package tpu_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DONE} state_t;

  localparam logic [3:0] REG_A   = 4'd1;
  localparam logic [3:0] REG_B   = 4'd2;
  localparam logic [3:0] REG_C   = 4'd3;
  localparam logic [3:0] REG_CSR = 4'd4;

  localparam int CSR_START = 0;  // command word bits
  localparam int CSR_ACC   = 1;
  localparam int CSR_BUSY  = 0;  // status word bits
  localparam int CSR_DONE  = 1;

  function automatic int words_per_row(input int dim, input int bits, input int dataw);
    return (dim * bits + dataw - 1) / dataw;
  endfunction

  function automatic int awpr(input int dim, input int bits_ab, input int dataw);
    return words_per_row(dim, bits_ab, dataw);
  endfunction

  function automatic int cwpr(input int dim, input int bits_c, input int dataw);
    return words_per_row(dim, bits_c, dataw);
  endfunction

  // Select width that stays legal when only one entry exists.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tpu_row_stager.sv
// Collects bus words of one matrix row; commit fires combinationally with the last word, and the
// returned row merges staged words with the word currently on the bus.
module tpu_row_stager #(
  parameter int DATAW = 64,
  parameter int ROWW  = 64,
  parameter int NW    = 1,
  parameter int WSW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WSW-1:0]   wsel,
  input  logic [DATAW-1:0] dat,
  output logic             commit,
  output logic [ROWW-1:0]  row
);

  logic [NW*DATAW-1:0] stage;
  logic [NW*DATAW-1:0] full;

  always_ff @(posedge clk) begin
    if (!rst_n) stage <= '0;
    else if (wr) stage[wsel*DATAW +: DATAW] <= dat;
  end

  always_comb begin
    full = stage;
    full[wsel*DATAW +: DATAW] = dat;
  end

  assign commit = wr && (wsel == WSW'(NW - 1));
  assign row    = full[ROWW-1:0];

endmodule

// File: rtl/tpuv2.sv
// Memory-mapped DIMxDIM matrix multiply engine: A/B/C row windows plus a CSR window.
// Reads return one cycle later; a command runs optional C clear then 3*DIM-2 compute cycles.
module tpuv2
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             r_w,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] dataIn,
  output logic [DATAW-1:0] dataOut,
  output logic             rd_valid,
  output logic             busy,
  output logic             done
);

  localparam int AWPR  = awpr(DIM, BITS_AB, DATAW);
  localparam int CWPR  = cwpr(DIM, BITS_C, DATAW);
  localparam int OFFB  = $clog2(DATAW / 8);
  localparam int WW    = ADDRW - 4;
  localparam int RW    = sel_w(DIM);
  localparam int AWSW  = sel_w(AWPR);
  localparam int CWSW  = sel_w(CWPR);
  localparam int CW    = $clog2(3 * DIM - 2);
  localparam int ABROW = DIM * BITS_AB;
  localparam int CROW  = DIM * BITS_C;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     k, b_cnt;
  logic              done_sticky;
  logic [3:0]        region;
  logic [WW-1:0]     word, ab_row, c_row;
  logic [AWSW-1:0]   ab_wsel;
  logic [CWSW-1:0]   c_wsel;
  logic              ab_ok, c_ok, wr_ok, rd, start;
  logic              a_wr, b_wr, c_wr, a_commit, b_commit, c_commit;
  logic [ABROW-1:0]  a_row, b_row;
  logic [CROW-1:0]   c_row_bits;
  logic [CWPR*DATAW-1:0] c_rd;
  logic [DATAW-1:0]  csr_stat;

  logic        [BITS_AB-1:0] a_mem [DIM][DIM];
  logic        [BITS_AB-1:0] b_mem [DIM][DIM];
  logic signed [BITS_C-1:0]  c_mem [DIM][DIM];

  function automatic logic signed [BITS_C-1:0] sx(input logic [BITS_AB-1:0] v);
    return BITS_C'(signed'(v));
  endfunction

  assign region  = addr[ADDRW-1 -: 4];
  assign word    = addr[WW-1:0] >> OFFB;
  assign ab_row  = word / WW'(AWPR);
  assign ab_wsel = AWSW'(word % WW'(AWPR));
  assign c_row   = word / WW'(CWPR);
  assign c_wsel  = CWSW'(word % WW'(CWPR));
  assign ab_ok   = ab_row < WW'(DIM);
  assign c_ok    = c_row < WW'(DIM);

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign wr_ok = req && r_w && !busy;
  assign rd    = req && !r_w;
  assign a_wr  = wr_ok && (region == REG_A) && ab_ok;
  assign b_wr  = wr_ok && (region == REG_B) && ab_ok;
  assign c_wr  = wr_ok && (region == REG_C) && c_ok;
  assign start = wr_ok && (region == REG_CSR) && (word == '0) && dataIn[CSR_START];
  assign k     = RW'(cnt);

  tpu_row_stager #(.DATAW(DATAW), .ROWW(ABROW), .NW(AWPR), .WSW(AWSW)) u_stage_a (
    .clk(clk), .rst_n(~rst), .wr(a_wr), .wsel(ab_wsel), .dat(dataIn),
    .commit(a_commit), .row(a_row));

  tpu_row_stager #(.DATAW(DATAW), .ROWW(ABROW), .NW(AWPR), .WSW(AWSW)) u_stage_b (
    .clk(clk), .rst_n(~rst), .wr(b_wr), .wsel(ab_wsel), .dat(dataIn),
    .commit(b_commit), .row(b_row));

  tpu_row_stager #(.DATAW(DATAW), .ROWW(CROW), .NW(CWPR), .WSW(CWSW)) u_stage_c (
    .clk(clk), .rst_n(~rst), .wr(c_wr), .wsel(c_wsel), .dat(dataIn),
    .commit(c_commit), .row(c_row_bits));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = dataIn[CSR_ACC] ? COMPUTE : CLEAR;
      CLEAR:   if (cnt == CW'(DIM - 1)) state_n = COMPUTE;
      COMPUTE: if (cnt == CW'(3 * DIM - 3)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // B rows land in arrival order, so the counter rather than the address picks the slot.
  always_ff @(posedge clk) begin
    if (a_commit)
      for (int j = 0; j < DIM; j++) a_mem[RW'(ab_row)][j] <= a_row[j*BITS_AB +: BITS_AB];
    if (b_commit)
      for (int j = 0; j < DIM; j++) b_mem[b_cnt][j] <= b_row[j*BITS_AB +: BITS_AB];
  end

  // One rank-1 update per compute cycle for the first DIM cycles; the rest drains the window.
  always_ff @(posedge clk) begin
    if (c_commit) begin
      for (int j = 0; j < DIM; j++) c_mem[RW'(c_row)][j] <= c_row_bits[j*BITS_C +: BITS_C];
    end else if (state == CLEAR) begin
      for (int j = 0; j < DIM; j++) c_mem[k][j] <= '0;
    end else if (state == COMPUTE && cnt < CW'(DIM)) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++)
          c_mem[i][j] <= c_mem[i][j] + sx(a_mem[i][k]) * sx(b_mem[k][j]);
    end
  end

  always_comb begin
    c_rd = '0;
    for (int j = 0; j < DIM; j++) c_rd[j*BITS_C +: BITS_C] = c_mem[RW'(c_row)][j];
    csr_stat = '0;
    csr_stat[CSR_BUSY] = busy;
    csr_stat[CSR_DONE] = done_sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      b_cnt       <= '0;
      done_sticky <= 1'b0;
      rd_valid    <= 1'b0;
      dataOut     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
      rd_valid <= rd;
      dataOut  <= '0;
      if (rd && region == REG_C && c_ok && !busy) dataOut <= c_rd[c_wsel*DATAW +: DATAW];
      if (rd && region == REG_CSR && word == WW'(1)) dataOut <= csr_stat;
      if (state == DONE) done_sticky <= 1'b1;
      else if (rd && region == REG_CSR) done_sticky <= 1'b0;
      if (b_commit) b_cnt <= (b_cnt == RW'(DIM - 1)) ? '0 : b_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_tpuv2.sv
// Scenario bench for tpuv2: bus tasks drive the DUT, a matrix-level model predicts C contents.
module tb_tpuv2;
  localparam int DIM = 8;
  localparam int EPW = 4;  // C elements per 64-bit bus word

  logic clk = 1'b0;
  logic rst, req, r_w, rd_valid, busy, done;
  logic [15:0] addr;
  logic [63:0] dataIn, dataOut;

  always #5 clk = ~clk;

  tpuv2 dut (
    .clk(clk), .rst(rst), .req(req), .r_w(r_w), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .rd_valid(rd_valid), .busy(busy), .done(done));

  int ma [DIM][DIM];
  int mb [DIM][DIM];
  int mc [DIM][DIM];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] mk_addr(input logic [3:0] region, input int word);
    logic [11:0] off;
    off = 12'(word * 8);
    return {region, off};
  endfunction

  function automatic int wrap16(input longint s);
    shortint t;
    t = shortint'(s);
    return int'(t);
  endfunction

  function automatic logic [63:0] exp_cword(input int r, input int w);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < EPW; j++) d[j*16 +: 16] = 16'(mc[r][w*EPW + j]);
    return d;
  endfunction

  // C = A*B (or C += A*B) with 16-bit two's-complement wrap
  task automatic model_mul(input bit acc);
    longint s;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        s = acc ? longint'(mc[i][j]) : 0;
        for (int kk = 0; kk < DIM; kk++) s += longint'(ma[i][kk] * mb[kk][j]);
        mc[i][j] = wrap16(s);
      end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    req = 1'b1; r_w = 1'b1; addr = a; dataIn = d;
    @(negedge clk);
    req = 1'b0; r_w = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [63:0] d, output logic v);
    @(negedge clk);
    req = 1'b1; r_w = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    d = dataOut;
    v = rd_valid;
  endtask

  task automatic write_matrices();
    logic [63:0] d;
    for (int i = 0; i < DIM; i++) begin
      d = '0;
      for (int j = 0; j < DIM; j++) d[j*8 +: 8] = 8'(ma[i][j]);
      bus_write(mk_addr(4'h1, i), d);
    end
    for (int i = 0; i < DIM; i++) begin
      d = '0;
      for (int j = 0; j < DIM; j++) d[j*8 +: 8] = 8'(mb[i][j]);
      bus_write(mk_addr(4'h2, i), d);
    end
  endtask

  task automatic check_all_c(input string tag);
    logic [63:0] d;
    logic v;
    for (int r = 0; r < DIM; r++)
      for (int w = 0; w < 2; w++) begin
        bus_read(mk_addr(4'h3, r*2 + w), d, v);
        vectors++;
        if (d !== exp_cword(r, w)) begin
          miscompares++;
          $display("FAIL %s c[%0d].w%0d: got %h expected %h", tag, r, w, d, exp_cword(r, w));
        end
      end
  endtask

  task automatic check_word(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [63:0] cmd, input int exp_busy, input string tag);
    int n, nd;
    bus_write(mk_addr(4'h4, 0), cmd);
    n = 0; nd = 0;
    while (busy && n < 200) begin
      if (done) nd++;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== exp_busy) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, exp_busy);
    end
    vectors++;
    if (nd !== 1) begin
      miscompares++;
      $display("FAIL %s done_pulses: got %0d expected 1", tag, nd);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_timeout: busy=%b after %0d cycles expected 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_word("reset_busy", 64'(busy), 64'd0);
    check_word("reset_done", 64'(done), 64'd0);
    check_word("reset_rd_valid", 64'(rd_valid), 64'd0);
    check_word("reset_dataOut", dataOut, 64'd0);
  endtask

  task automatic test_identity();
    logic [63:0] d;
    logic v;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i*8 + j;
      end
    write_matrices();
    run_cmd(64'h1, 31, "identity");
    model_mul(1'b0);
    bus_read(mk_addr(4'h3, 4), d, v);
    check_word("identity_row2_w0", d, 64'h0013_0012_0011_0010);
    check_word("identity_rd_valid", 64'(v), 64'd1);
    check_all_c("identity");
  endtask

  task automatic test_accumulate();
    logic [63:0] d;
    logic v;
    write_matrices();
    run_cmd(64'h3, 23, "accumulate");
    model_mul(1'b1);
    bus_read(mk_addr(4'h3, 4), d, v);
    check_word("accum_row2_w0", d, 64'h0026_0024_0022_0020);
    check_all_c("accumulate");
  endtask

  task automatic test_signed();
    logic [63:0] d;
    logic v;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = -1;
        mb[i][j] = 1;
      end
    write_matrices();
    run_cmd(64'h1, 31, "signed");
    model_mul(1'b0);
    bus_read(mk_addr(4'h3, 15), d, v);
    check_word("signed_row7_w1", d, 64'hFFF8_FFF8_FFF8_FFF8);
    check_all_c("signed");
  endtask

  task automatic test_random();
    bit acc;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          ma[i][j] = int'($urandom_range(255)) - 128;
          mb[i][j] = int'($urandom_range(255)) - 128;
        end
      acc = 1'($urandom_range(1));
      write_matrices();
      run_cmd(acc ? 64'h3 : 64'h1, acc ? 23 : 31, "random");
      model_mul(acc);
      check_all_c("random");
    end
  endtask

  task automatic test_busy_protect();
    logic [63:0] d;
    logic v;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = int'($urandom_range(255)) - 128;
        mb[i][j] = int'($urandom_range(255)) - 128;
      end
    write_matrices();
    bus_read(mk_addr(4'h4, 0), d, v);
    check_word("csr_w0_read", d, 64'd0);
    bus_write(mk_addr(4'h4, 0), 64'h1);
    bus_write(mk_addr(4'h1, 0), {$urandom, $urandom});
    bus_read(mk_addr(4'h3, 0), d, v);
    check_word("busy_c_read", d, 64'd0);
    check_word("busy_c_rd_valid", 64'(v), 64'd1);
    bus_read(mk_addr(4'h4, 1), d, v);
    check_word("busy_csr_status", d, 64'h1);
    bus_write(mk_addr(4'h4, 0), 64'h3);
    wait_idle("busy_protect");
    bus_read(mk_addr(4'h4, 1), d, v);
    check_word("after_done_status", d, 64'h2);
    bus_read(mk_addr(4'h4, 1), d, v);
    check_word("sticky_cleared", d, 64'h0);
    model_mul(1'b0);
    check_all_c("busy_protect");
  endtask

  task automatic test_partial_oob();
    logic [63:0] d, d0, d1;
    logic v;
    d = {$urandom, $urandom};
    bus_write(mk_addr(4'h3, 6), d);
    bus_read(mk_addr(4'h3, 6), d0, v);
    check_word("partial_row3_w0", d0, exp_cword(3, 0));
    bus_write(mk_addr(4'h3, 18), d);
    bus_read(mk_addr(4'h3, 18), d0, v);
    check_word("oob_row9_read", d0, 64'd0);
    check_word("oob_row9_rd_valid", 64'(v), 64'd1);
    bus_write(mk_addr(4'h7, 0), d);
    bus_read(mk_addr(4'h7, 0), d0, v);
    check_word("region7_read", d0, 64'd0);
    check_word("region7_rd_valid", 64'(v), 64'd1);
    bus_read(mk_addr(4'h1, 0), d0, v);
    check_word("a_read_zero", d0, 64'd0);
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    bus_write(mk_addr(4'h3, 10), d0);
    bus_write(mk_addr(4'h3, 11), d1);
    for (int j = 0; j < EPW; j++) begin
      mc[5][j]       = int'(shortint'(d0[j*16 +: 16]));
      mc[5][j + EPW] = int'(shortint'(d1[j*16 +: 16]));
    end
    check_all_c("partial_oob");
  endtask

  task automatic test_reset_mid();
    bus_write(mk_addr(4'h4, 0), 64'h1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_word("midrst_busy", 64'(busy), 64'd0);
    check_word("midrst_done", 64'(done), 64'd0);
    check_word("midrst_dataOut", dataOut, 64'd0);
    run_cmd(64'h1, 31, "after_reset");
    model_mul(1'b0);
    check_all_c("after_reset");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_accumulate();
    test_signed();
    test_random();
    test_busy_protect();
    test_partial_oob();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tpuv2.md
Name: tpuv2

Overview:
Second-generation memory-mapped TPU top. It wraps memA, memB and systolic_array behind a request-based bus with separate A, B, C and CSR address windows. A row may span several bus words; words are staged and the row is committed when its last word arrives. A command FSM sequences an optional C clear followed by the multiply, reports busy/done, and supports an accumulate mode (C += A×B).

Parameters:
BITS_AB, 8, signed A/B element width
BITS_C, 16, signed C element/accumulator width
DIM, 8, array dimension (DIM×DIM)
ADDRW, 16, byte address width
DATAW, 64, bus data width; must be a multiple of 8

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  1  bus request; one access per cycle when high
r_w  in  1  0=read, 1=write; sampled with req
addr  in  ADDRW  byte address; low $clog2(DATAW/8) bits ignored
dataIn  in  DATAW  write data
dataOut  out  DATAW  registered read data
rd_valid  out  1  high for one cycle, the cycle after an accepted read
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset: all outputs 0, FSM=IDLE, staging buffers cleared, CSR=0. Submodules receive rst_n = ~rst. Reset mid-command aborts to IDLE the next edge.
- Derived constants:
  - AWPR = ceil(DIM*BITS_AB/DATAW): words per A/B row.
  - CWPR = ceil(DIM*BITS_C/DATAW): words per C row.
- Address decode:
  - region = addr[ADDRW-1 -: 4]: 1=A, 2=B, 3=C, 4=CSR; all other regions are invalid.
  - word = offset >> $clog2(DATAW/8).
  - For A/B: row = word / AWPR, wsel = word % AWPR. For C: uses CWPR.
  - Row >= DIM is out of range.
- Packing:
  - Element j occupies row bits [j*BITS +: BITS].
  - Bus word w carries row bits [w*DATAW +: DATAW].
  - The final word is zero-padded on read; pad bits are ignored on write.
- Write A/C:
  - The word is stored in the staging slot at wsel.
  - When wsel = last word, the full row (staged words plus the current word) is committed to that row the same cycle, via memA WrEn/Arow or systolic_array WrEn/Crow.
- Write B: staged the same way. On the last word the row is shifted into memB (en_b, one cycle). Rows must be written 0..DIM-1; a B row counter tracks them.
- Reads:
  - A/B/CSR reads return 0, except CSR word 1 = {done_sticky, busy}.
  - C read returns word wsel of Cout for Crow=row.
  - dataOut and rd_valid are registered, latency 1.
- CSR write word 0, accepted only in IDLE:
  - bit0 = start; bit1 = accumulate.
  - start=0 has no effect.
- FSM:
  - IDLE → CLEAR on start with accumulate=0; IDLE → COMPUTE on start with accumulate=1.
  - CLEAR: DIM cycles writing zero to Crow 0..DIM-1 → COMPUTE.
  - COMPUTE: en_a/en_sys (and en_b for shift-out) held for exactly 3*DIM-2 cycles via counter → DONE.
  - DONE: 1 cycle, done=1, done_sticky set → IDLE.
  - done_sticky clears on a CSR read.
- Busy rules:
  - While busy, writes to any region are ignored.
  - Reads of A/B/C return 0 but still assert rd_valid; CSR reads behave normally.
- Other boundaries:
  - Invalid region or out-of-range row: write ignored; read returns 0 with rd_valid=1.
  - A new start while busy is ignored.
  - Arithmetic is signed with BITS_C wrap-around; no saturation.
- Latency: with DIM=8, busy is high for 31 cycles without accumulate and 23 cycles with accumulate, starting the cycle after the start write.

Decomposition:
- Package tpu_pkg holds:
  - state_t {IDLE, CLEAR, COMPUTE, DONE}.
  - Region codes REG_A/REG_B/REG_C/REG_CSR.
  - CSR bit indices.
  - AWPR/CWPR helper functions.
- One natural sub-module: tpu_row_stager (parametrised row width, word count). It stages words and emits a commit pulse plus the full row, and is instantiated for A, B and C.

Test Plan:
- Identity multiply (DIM=8):
  - Write A = I and B[i][j] = i*8+j, then CSR word0 = 1.
  - Expect busy for 31 cycles and a one-cycle done.
  - C row2 word0 = 0x0013_0012_0011_0010.
- Accumulate: repeat the identity multiply with CSR word0 = 3. Expect busy for 23 cycles and row2 word0 = 0x0026_0024_0022_0020.
- Signed: A all 0xFF, B all 0x01, start=1. Every C word = 0xFFF8_FFF8_FFF8_FFF8.
- Busy protection:
  - Write an A row during COMPUTE; it is ignored and results match the pre-write data.
  - A C read during busy returns 0 with rd_valid=1.
  - CSR word1 reads 0x1 during busy and 0x2 after done; the next CSR read returns 0x0.
- Partial row / out of range:
  - Write C row3 word0 only; row3 is unchanged on readback.
  - Write C row9 or region 0x7: ignored, and reads return 0.
- Reset mid-COMPUTE: assert rst for 1 cycle. Next cycle busy=0, done=0, dataOut=0; a new start runs normally.
